// File: rtl/nios_qsys_shared_memory_arbiter.sv
// Round-robin arbiter sharing port 2 of the dual-port RAM between two Avalon-MM masters.
// Each access runs IDLE -> ISSUE (-> DATA for reads) to match the RAM's 1-cycle read latency.
module nios_qsys_shared_memory_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_waitrequest,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_waitrequest,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic [DATA_W-1:0]   mem_writedata,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic [CNT_W-1:0]    grant_cnt0,
  output logic [CNT_W-1:0]    grant_cnt1,
  output logic                proto_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DATA
  } state_t;

  state_t state, state_nxt;
  logic   grant, grant_nxt;
  logic   is_write, is_write_nxt;
  logic   last_grant, last_grant_nxt;
  logic   cnt_inc;
  logic   req0, req1;
  logic   both_rw;

  assign req0    = m0_read | m0_write;
  assign req1    = m1_read | m1_write;
  assign both_rw = (m0_read & m0_write) | (m1_read & m1_write);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      grant      <= 1'b0;
      is_write   <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      is_write   <= is_write_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    is_write_nxt   = is_write;
    last_grant_nxt = last_grant;
    cnt_inc        = 1'b0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    m0_readdata    = '0;
    m1_readdata    = '0;
    mem_address    = grant ? m1_address    : m0_address;
    mem_byteenable = grant ? m1_byteenable : m0_byteenable;
    mem_writedata  = grant ? m1_writedata  : m0_writedata;
    unique case (state)
      S_IDLE: begin
        if (req0 | req1) begin
          grant_nxt      = (req0 & req1) ? ~last_grant : req1;
          // write wins when a master raises read and write together
          is_write_nxt   = grant_nxt ? m1_write : m0_write;
          last_grant_nxt = grant_nxt;
          state_nxt      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mem_chipselect = 1'b1;
        mem_write      = is_write;
        if (is_write) begin
          m0_waitrequest = grant;
          m1_waitrequest = ~grant;
          cnt_inc        = 1'b1;
          state_nxt      = S_IDLE;
        end else begin
          state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        m0_waitrequest = grant;
        m1_waitrequest = ~grant;
        if (grant) m1_readdata = mem_readdata;
        else       m0_readdata = mem_readdata;
        cnt_inc   = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
      proto_err  <= 1'b0;
    end else begin
      if (cnt_inc && !grant && grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + CNT_W'(1);
      if (cnt_inc &&  grant && grant_cnt1 != '1) grant_cnt1 <= grant_cnt1 + CNT_W'(1);
      if (state == S_IDLE && both_rw) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_nios_qsys_shared_memory_arbiter.sv
// Randomized bench for the shared-memory arbiter: transaction-level model with
// round-robin choice, byte-enable memory image and saturating grant counts.
`timescale 1ns/1ps
module tb_nios_qsys_shared_memory_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BW = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic          rd [2];
  logic          wr [2];
  logic [AW-1:0] ad [2];
  logic [BW-1:0] be [2];
  logic [DW-1:0] wd [2];

  logic [DW-1:0] m0_readdata, m1_readdata;
  logic          m0_waitrequest, m1_waitrequest;
  logic          mem_chipselect, mem_write;
  logic [AW-1:0] mem_address;
  logic [BW-1:0] mem_byteenable;
  logic [DW-1:0] mem_writedata, mem_readdata;
  logic [15:0]   grant_cnt0, grant_cnt1;
  logic          proto_err;

  logic [DW-1:0] s_m0_readdata, s_m1_readdata, s_wd;
  logic          s_m0_wait, s_m1_wait, s_cs, s_we, s_perr;
  logic [AW-1:0] s_addr;
  logic [BW-1:0] s_be;
  logic [3:0]    s_cnt0, s_cnt1;

  nios_qsys_shared_memory_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(ad[0]), .m0_read(rd[0]), .m0_write(wr[0]), .m0_byteenable(be[0]),
    .m0_writedata(wd[0]), .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
    .m1_address(ad[1]), .m1_read(rd[1]), .m1_write(wr[1]), .m1_byteenable(be[1]),
    .m1_writedata(wd[1]), .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_address(mem_address),
    .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1),
    .proto_err(proto_err)
  );

  // Narrow-counter build sharing the same stimulus, used for saturation checks.
  nios_qsys_shared_memory_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(4)) dut_s (
    .clk(clk), .reset_n(reset_n),
    .m0_address(ad[0]), .m0_read(rd[0]), .m0_write(wr[0]), .m0_byteenable(be[0]),
    .m0_writedata(wd[0]), .m0_readdata(s_m0_readdata), .m0_waitrequest(s_m0_wait),
    .m1_address(ad[1]), .m1_read(rd[1]), .m1_write(wr[1]), .m1_byteenable(be[1]),
    .m1_writedata(wd[1]), .m1_readdata(s_m1_readdata), .m1_waitrequest(s_m1_wait),
    .mem_chipselect(s_cs), .mem_write(s_we), .mem_address(s_addr),
    .mem_byteenable(s_be), .mem_writedata(s_wd),
    .mem_readdata('0), .grant_cnt0(s_cnt0), .grant_cnt1(s_cnt1),
    .proto_err(s_perr)
  );

  // RAM port 2: registered address, unregistered q.
  logic [DW-1:0] ram [1024];
  logic [DW-1:0] ram_q;
  assign mem_readdata = ram_q;

  function automatic logic [DW-1:0] ram_merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                              input logic [BW-1:0] b);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < BW; i++) if (b[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) ram[mem_address] <= ram_merge(ram[mem_address], mem_writedata, mem_byteenable);
      else           ram_q <= ram[mem_address];
    end
  end

  typedef struct {
    bit            r;
    bit            w;
    logic [AW-1:0] a;
    logic [BW-1:0] be;
    logic [DW-1:0] d;
    int            gap;
  } op_t;

  op_t oq [2][$];
  bit  act [2];
  int  wait_c [2];
  int  start_cyc [2];
  int  lat [2];
  logic [DW-1:0] rdata_seen [2];
  int  order [$];
  int  first_done;
  int  cyc;

  // Reference model: one transfer in flight, phase counts remaining active cycles.
  int            m_phase;
  int            m_g;
  int            m_last;
  bit            m_w;
  logic [AW-1:0] m_a;
  logic [BW-1:0] m_be;
  logic [DW-1:0] m_d;
  bit            m_perr;
  int            cnt [2];
  int            cnt_s [2];
  logic [DW-1:0] ref_mem [1024];

  int checks = 0;
  int errors = 0;

  function automatic logic [DW-1:0] be_mask(input logic [BW-1:0] b);
    return {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
  endfunction

  task automatic model_reset();
    m_phase = 0; m_last = 1; m_perr = 0; m_g = 0; m_w = 0;
    cnt[0] = 0; cnt[1] = 0; cnt_s[0] = 0; cnt_s[1] = 0;
    for (int n = 0; n < 2; n++) begin
      oq[n].delete(); act[n] = 0; wait_c[n] = 0;
      rd[n] = 0; wr[n] = 0; ad[n] = '0; be[n] = '0; wd[n] = '0;
    end
  endtask

  task automatic step();
    bit done [2];
    op_t op;
    logic ow;
    logic [DW-1:0] ord;
    logic exp_w;
    logic [DW-1:0] exp_rd;
    logic exp_cs;
    @(posedge clk);
    cyc++;
    done[0] = 0; done[1] = 0;
    if (m_phase == 0) begin
      if ((rd[0] & wr[0]) | (rd[1] & wr[1])) m_perr = 1;
      if (rd[0] | wr[0] | rd[1] | wr[1]) begin
        if ((rd[0] | wr[0]) && (rd[1] | wr[1])) m_g = 1 - m_last;
        else m_g = (rd[0] | wr[0]) ? 0 : 1;
        m_last = m_g; m_w = wr[m_g]; m_a = ad[m_g]; m_be = be[m_g]; m_d = wd[m_g];
        m_phase = m_w ? 1 : 2;
      end
    end else if (m_phase == 1) begin
      if (m_w) ref_mem[m_a] = (ref_mem[m_a] & ~be_mask(m_be)) | (m_d & be_mask(m_be));
      if (cnt[m_g] < 65535) cnt[m_g]++;
      if (cnt_s[m_g] < 15) cnt_s[m_g]++;
      done[m_g] = 1;
      order.push_back(m_g);
      if (first_done < 0) first_done = m_g;
      m_phase = 0;
    end else begin
      m_phase = 1;
    end
    #1;
    for (int n = 0; n < 2; n++) begin
      if (done[n]) begin
        lat[n] = cyc - start_cyc[n]; act[n] = 0; rd[n] = 0; wr[n] = 0;
      end
      if (!act[n] && oq[n].size() > 0) begin
        if (wait_c[n] < oq[n][0].gap) wait_c[n]++;
        else begin
          op = oq[n].pop_front();
          rd[n] = op.r; wr[n] = op.w; ad[n] = op.a; be[n] = op.be; wd[n] = op.d;
          act[n] = 1; start_cyc[n] = cyc; wait_c[n] = 0;
        end
      end
    end
    @(negedge clk);
    for (int n = 0; n < 2; n++) begin
      ow     = (n == 0) ? m0_waitrequest : m1_waitrequest;
      ord    = (n == 0) ? m0_readdata : m1_readdata;
      exp_w  = !(m_phase == 1 && m_g == n);
      exp_rd = (m_phase == 1 && !m_w && m_g == n) ? ref_mem[m_a] : '0;
      checks += 2;
      if (ow !== exp_w) begin
        errors++; $display("FAIL waitrequest m%0d cyc %0d: got %b expected %b", n, cyc, ow, exp_w);
      end
      if (ord !== exp_rd) begin
        errors++; $display("FAIL readdata m%0d cyc %0d: got %h expected %h", n, cyc, ord, exp_rd);
      end
      if (m_phase == 1 && !m_w && m_g == n) rdata_seen[n] = ord;
    end
    exp_cs = (m_phase == 2) || (m_phase == 1 && m_w);
    checks += 6;
    if (mem_chipselect !== exp_cs) begin
      errors++; $display("FAIL mem_chipselect cyc %0d: got %b expected %b", cyc, mem_chipselect, exp_cs);
    end
    if (mem_write !== (m_phase == 1 && m_w)) begin
      errors++; $display("FAIL mem_write cyc %0d: got %b expected %b", cyc, mem_write, (m_phase == 1 && m_w));
    end
    if (exp_cs && (mem_address !== m_a || mem_byteenable !== m_be || (m_w && mem_writedata !== m_d))) begin
      errors++;
      $display("FAIL mem_bus cyc %0d: got a=%h be=%h d=%h expected a=%h be=%h d=%h",
               cyc, mem_address, mem_byteenable, mem_writedata, m_a, m_be, m_d);
    end
    if (grant_cnt0 !== 16'(cnt[0]) || grant_cnt1 !== 16'(cnt[1])) begin
      errors++; $display("FAIL grant_cnt cyc %0d: got %0d/%0d expected %0d/%0d",
                         cyc, grant_cnt0, grant_cnt1, cnt[0], cnt[1]);
    end
    if (s_cnt0 !== 4'(cnt_s[0]) || s_cnt1 !== 4'(cnt_s[1])) begin
      errors++; $display("FAIL grant_cnt_sat cyc %0d: got %0d/%0d expected %0d/%0d",
                         cyc, s_cnt0, s_cnt1, cnt_s[0], cnt_s[1]);
    end
    if (proto_err !== m_perr) begin
      errors++; $display("FAIL proto_err cyc %0d: got %b expected %b", cyc, proto_err, m_perr);
    end
  endtask

  task automatic run_until_idle(input int budget);
    int k;
    k = 0;
    while ((oq[0].size() > 0 || oq[1].size() > 0 || act[0] || act[1] || m_phase != 0) && k < budget) begin
      step(); k++;
    end
    checks++;
    if (k >= budget) begin
      errors++; $display("FAIL timeout: got %0d cycles expected fewer than %0d", k, budget);
    end
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic push_op(input int n, input bit r, input bit w, input logic [AW-1:0] a,
                         input logic [BW-1:0] b, input logic [DW-1:0] d, input int gap);
    op_t op;
    op.r = r; op.w = w; op.a = a; op.be = b; op.d = d; op.gap = gap;
    oq[n].push_back(op);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 4;
    if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin
      errors++; $display("FAIL reset_wait: got %b%b expected 11", m0_waitrequest, m1_waitrequest);
    end
    if (mem_chipselect !== 1'b0 || mem_write !== 1'b0) begin
      errors++; $display("FAIL reset_mem: got cs=%b we=%b expected 0 0", mem_chipselect, mem_write);
    end
    if (m0_readdata !== '0 || m1_readdata !== '0) begin
      errors++; $display("FAIL reset_rdata: got %h %h expected 0", m0_readdata, m1_readdata);
    end
    if (grant_cnt0 !== '0 || grant_cnt1 !== '0 || proto_err !== 1'b0) begin
      errors++; $display("FAIL reset_regs: got %0d %0d %b expected 0 0 0", grant_cnt0, grant_cnt1, proto_err);
    end
    reset_n = 1'b1;
  endtask

  task automatic preload();
    for (int a = 0; a < 8; a++) push_op(0, 0, 1, AW'(a), 4'hF, '0, 0);
    push_op(1, 0, 1, 10'h3FF, 4'hF, '0, 0);
    push_op(1, 0, 1, 10'h010, 4'hF, '0, 0);
    run_until_idle(100);
  endtask

  task automatic test_write_read();
    apply_reset();
    push_op(0, 0, 1, 10'h005, 4'hF, 32'hDEADBEEF, 0);
    run_until_idle(20);
    checks++;
    if (lat[0] !== 2) begin errors++; $display("FAIL write_latency: got %0d expected 2", lat[0]); end
    push_op(0, 1, 0, 10'h005, 4'hF, '0, 0);
    run_until_idle(20);
    checks += 3;
    if (lat[0] !== 3) begin errors++; $display("FAIL read_latency: got %0d expected 3", lat[0]); end
    if (rdata_seen[0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL read_data: got %h expected deadbeef", rdata_seen[0]);
    end
    if (grant_cnt0 !== 16'd2) begin errors++; $display("FAIL write_read_cnt: got %0d expected 2", grant_cnt0); end
  endtask

  task automatic test_fairness();
    apply_reset();
    order.delete();
    for (int i = 0; i < 4; i++)
      for (int n = 0; n < 2; n++) begin
        bit r;
        r = 1'($urandom_range(0, 1));
        push_op(n, r, !r, AW'($urandom_range(0, 7)), 4'($urandom), $urandom, 0);
      end
    run_until_idle(100);
    checks += 2;
    for (int i = 0; i < order.size(); i++) begin
      checks++;
      if (order[i] !== i % 2) begin
        errors++; $display("FAIL grant_order[%0d]: got m%0d expected m%0d", i, order[i], i % 2);
      end
    end
    if (order.size() !== 8) begin errors++; $display("FAIL fair_count: got %0d expected 8", order.size()); end
    if (grant_cnt0 !== 16'd4 || grant_cnt1 !== 16'd4) begin
      errors++; $display("FAIL fair_cnt: got %0d/%0d expected 4/4", grant_cnt0, grant_cnt1);
    end
  endtask

  task automatic test_byte_enable();
    push_op(1, 0, 1, 10'h3FF, 4'hF, 32'hFFFFFFFF, 0);
    push_op(1, 0, 1, 10'h3FF, 4'h3, 32'h1234ABCD, 0);
    push_op(1, 1, 0, 10'h3FF, 4'hF, '0, 0);
    run_until_idle(30);
    checks++;
    if (rdata_seen[1] !== 32'hFFFFABCD) begin
      errors++; $display("FAIL byte_enable: got %h expected ffffabcd", rdata_seen[1]);
    end
  endtask

  task automatic test_proto_err();
    logic [DW-1:0] d;
    d = $urandom;
    push_op(0, 1, 1, 10'h010, 4'hF, d, 0);
    push_op(0, 1, 0, 10'h010, 4'hF, '0, 0);
    run_until_idle(30);
    checks += 2;
    if (rdata_seen[0] !== d) begin errors++; $display("FAIL rw_write_wins: got %h expected %h", rdata_seen[0], d); end
    if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_err_set: got %b expected 1", proto_err); end
    repeat (100) step();
    checks++;
    if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_err_sticky: got %b expected 1", proto_err); end
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int i = 0; i < 20; i++) push_op(0, 0, 1, AW'($urandom_range(0, 7)), 4'($urandom), $urandom, 0);
    run_until_idle(200);
    checks += 2;
    if (s_cnt0 !== 4'd15) begin errors++; $display("FAIL saturate: got %0d expected 15", s_cnt0); end
    if (grant_cnt0 !== 16'd20) begin errors++; $display("FAIL wide_cnt: got %0d expected 20", grant_cnt0); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 60; i++)
      for (int n = 0; n < 2; n++) begin
        bit r, w;
        r = 1'($urandom_range(0, 1));
        w = !r;
        if ($urandom_range(0, 19) == 0) begin r = 1; w = 1; end
        push_op(n, r, w, ($urandom_range(0, 8) == 8) ? 10'h3FF : AW'($urandom_range(0, 7)),
                4'($urandom), $urandom, $urandom_range(0, 3));
      end
    run_until_idle(3000);
  endtask

  task automatic test_reset_mid();
    int k;
    push_op(1, 1, 0, AW'($urandom_range(0, 7)), 4'hF, '0, 0);
    k = 0;
    while (!(m_phase == 1 && m_g == 1) && k < 20) begin step(); k++; end
    checks++;
    if (k >= 20) begin errors++; $display("FAIL reach_data: got %0d cycles expected fewer than 20", k); end
    reset_n = 1'b0;
    #1;
    checks += 3;
    if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin
      errors++; $display("FAIL async_wait: got %b%b expected 11", m0_waitrequest, m1_waitrequest);
    end
    if (mem_chipselect !== 1'b0) begin errors++; $display("FAIL async_cs: got %b expected 0", mem_chipselect); end
    if (m1_readdata !== '0) begin errors++; $display("FAIL async_rdata: got %h expected 0", m1_readdata); end
    apply_reset();
    first_done = -1;
    push_op(0, 0, 1, 10'h002, 4'hF, $urandom, 0);
    push_op(1, 0, 1, 10'h003, 4'hF, $urandom, 0);
    run_until_idle(30);
    checks++;
    if (first_done !== 0) begin errors++; $display("FAIL tie_after_reset: got m%0d expected m0", first_done); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    cyc = 0;
    first_done = -1;
    model_reset();
    test_reset();
    preload();
    test_write_read();
    test_fairness();
    test_byte_enable();
    test_proto_err();
    test_saturation();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog");
  end

endmodule
